// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC selector with a return-address stack.
// Ports: clk/reset (sync, active-high); pc_write enables an update; pc_src picks
//   sequential/branch/jump/return; call marks a jump as a call (pushes pc_add_result).
//   pc_result is the registered PC; ras_empty/ras_full reflect the stack count;
//   ras_err and misalign_err are sticky until reset.
// Optional feature macro: PC_ALIGN_CHECK_EN (odd branch/jump/return targets are
//   rejected and flagged; when undefined, bit0 of the next PC is forced to 0).
module pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic [1:0]  pc_src,
    input  logic        call,
    input  logic [15:0] pc_add_result,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    output logic [15:0] pc_result,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_err,
    output logic        misalign_err
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_RETURN = 2'b11;

    logic [15:0]   stack [RAS_DEPTH];
    logic [CW-1:0] count;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;

    logic [15:0] sel_pc;
    logic [15:0] next_pc;
    logic        do_push;
    logic        do_pop;
    logic        ras_event;

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    // Top entry sits one below the count; the next free slot is at the count.
    assign top_idx   = AW'(count - CW'(1));
    assign push_idx  = count[AW-1:0];

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        sel_pc    = pc_add_result;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ras_event = 1'b0;
        case (pc_src)
            SRC_SEQ:    sel_pc = pc_add_result;
            SRC_BRANCH: sel_pc = branch_target;
            SRC_JUMP: begin
                sel_pc = jump_target;
                // A call on a full stack still jumps; only the push is lost.
                if (call) begin
                    if (ras_full) ras_event = 1'b1;
                    else          do_push   = 1'b1;
                end
            end
            SRC_RETURN: begin
                // Return on an empty stack falls through to the sequential PC.
                if (ras_empty) begin
                    sel_pc    = pc_add_result;
                    ras_event = 1'b1;
                end else begin
                    sel_pc = stack[top_idx];
                    do_pop = 1'b1;
                end
            end
            default: sel_pc = pc_add_result;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        // An odd non-sequential target cancels the whole update, stack included.
        misaligned = (pc_src != SRC_SEQ) && sel_pc[0];
        if (misaligned) begin
            do_push   = 1'b0;
            do_pop    = 1'b0;
            ras_event = 1'b0;
            next_pc   = pc_result;
        end else begin
            next_pc   = sel_pc;
        end
`else
        next_pc = {sel_pc[15:1], 1'b0};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_result <= RESET_PC;
            count     <= '0;
            ras_err   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else if (pc_write) begin
            pc_result <= next_pc;
            if (do_push)   count   <= count + CW'(1);
            if (do_pop)    count   <= count - CW'(1);
            if (ras_event) ras_err <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (misaligned) misalign_q <= 1'b1;
`endif
        end
    end

    // Stack storage is not reset; only the count defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && pc_write && do_push) begin
            stack[push_idx] <= pc_add_result;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
    localparam logic [15:0] RST_PC = 16'h0100;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset, pc_write, call;
    logic [1:0]  pc_src;
    logic [15:0] pc_add_result, branch_target, jump_target;
    logic [15:0] pc_result;
    logic        ras_empty, ras_full, ras_err, misalign_err;

    int checks = 0;
    int errors = 0;

    pc_unit #(.RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src), .call(call),
        .pc_add_result(pc_add_result), .branch_target(branch_target),
        .jump_target(jump_target), .pc_result(pc_result), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Reference model: PC value, return stack as a queue, sticky flags.
    logic [15:0] mpc;
    logic [15:0] mras [$];
    bit          merr, mmis;

    task automatic model_step(input bit rst, input bit pw, input logic [1:0] src,
                              input bit cl, input logic [15:0] add,
                              input logic [15:0] br, input logic [15:0] jt);
        logic [15:0] sel;
        if (rst) begin
            mpc = RST_PC; mras.delete(); merr = 0; mmis = 0;
            return;
        end
        if (!pw) return;
        case (src)
            2'd0: sel = add;
            2'd1: sel = br;
            2'd2: sel = jt;
            default: sel = (mras.size() > 0) ? mras[$] : add;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if (src != 2'd0 && sel[0]) begin
            mmis = 1;
            return;
        end
`else
        sel[0] = 1'b0;
`endif
        if (src == 2'd2 && cl) begin
            if (mras.size() == DEPTH) merr = 1;
            else mras.push_back(add);
        end
        if (src == 2'd3) begin
            if (mras.size() == 0) merr = 1;
            else void'(mras.pop_back());
        end
        mpc = sel;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc_result, mpc);
        chk({tag, ".empty"}, 16'(ras_empty), 16'(mras.size() == 0));
        chk({tag, ".full"},  16'(ras_full),  16'(mras.size() == DEPTH));
        chk({tag, ".err"},   16'(ras_err),   16'(merr));
        chk({tag, ".mis"},   16'(misalign_err), 16'(mmis));
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit rst, input bit pw, input logic [1:0] src,
                        input bit cl, input logic [15:0] add,
                        input logic [15:0] br, input logic [15:0] jt);
        reset = rst; pc_write = pw; pc_src = src; call = cl;
        pc_add_result = add; branch_target = br; jump_target = jt;
        @(posedge clk);
        model_step(rst, pw, src, cl, add, br, jt);
        #1;
    endtask

    typedef struct {
        bit          rst, pw, cl;
        logic [1:0]  src;
        logic [15:0] add, br, jt;
        logic [15:0] e_pc;
        bit          e_empty, e_full, e_err, e_mis;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(bit rst, bit pw, logic [1:0] src, bit cl,
                                logic [15:0] add, logic [15:0] br, logic [15:0] jt,
                                logic [15:0] e_pc, bit e_empty, bit e_err, bit e_mis);
        vec_t v;
        v.rst = rst; v.pw = pw; v.src = src; v.cl = cl;
        v.add = add; v.br = br; v.jt = jt;
        v.e_pc = e_pc; v.e_empty = e_empty; v.e_full = 1'b0;
        v.e_err = e_err; v.e_mis = e_mis;
        return v;
    endfunction

    logic [15:0] pushed [DEPTH+1];
    logic [15:0] pc_before;

    initial begin
        reset = 1; pc_write = 0; pc_src = 0; call = 0;
        pc_add_result = 0; branch_target = 0; jump_target = 0;
        mpc = 16'hxxxx; merr = 0; mmis = 0;

        vt[0]  = mk(1, 0, 2'd0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1, 0, 0);
        vt[1]  = mk(0, 1, 2'd0, 0, 16'h0102, 16'h0000, 16'h0000, 16'h0102, 1, 0, 0);
        vt[2]  = mk(0, 1, 2'd0, 0, 16'h0104, 16'h0000, 16'h0000, 16'h0104, 1, 0, 0);
        vt[3]  = mk(0, 1, 2'd0, 0, 16'h0106, 16'h0000, 16'h0000, 16'h0106, 1, 0, 0);
        vt[4]  = mk(0, 1, 2'd1, 0, 16'h0108, 16'h0200, 16'h0000, 16'h0200, 1, 0, 0);
        vt[5]  = mk(0, 1, 2'd2, 1, 16'h0202, 16'h0000, 16'h0400, 16'h0400, 0, 0, 0);
        vt[6]  = mk(0, 1, 2'd3, 0, 16'h0402, 16'h0000, 16'h0000, 16'h0202, 1, 0, 0);
        vt[7]  = mk(0, 1, 2'd3, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0010, 1, 1, 0);
`ifdef PC_ALIGN_CHECK_EN
        vt[8]  = mk(0, 1, 2'd2, 0, 16'h0012, 16'h0000, 16'h0301, 16'h0010, 1, 1, 1);
`else
        vt[8]  = mk(0, 1, 2'd2, 0, 16'h0012, 16'h0000, 16'h0301, 16'h0300, 1, 1, 0);
`endif
        vt[9]  = mk(1, 1, 2'd2, 1, 16'h0302, 16'h0000, 16'h0500, 16'h0100, 1, 0, 0);
        // call with a branch select must not push: the following return underflows
        vt[10] = mk(0, 1, 2'd1, 1, 16'h0102, 16'h0220, 16'h0000, 16'h0220, 1, 0, 0);
        vt[11] = mk(0, 1, 2'd3, 0, 16'h0222, 16'h0000, 16'h0000, 16'h0222, 1, 1, 0);

        for (int i = 0; i < 12; i++) begin
            step(vt[i].rst, vt[i].pw, vt[i].src, vt[i].cl, vt[i].add, vt[i].br, vt[i].jt);
            chk($sformatf("vec%0d.pc", i),    pc_result, vt[i].e_pc);
            chk($sformatf("vec%0d.empty", i), 16'(ras_empty), 16'(vt[i].e_empty));
            chk($sformatf("vec%0d.full", i),  16'(ras_full),  16'(vt[i].e_full));
            chk($sformatf("vec%0d.err", i),   16'(ras_err),   16'(vt[i].e_err));
            chk($sformatf("vec%0d.mis", i),   16'(misalign_err), 16'(vt[i].e_mis));
        end

        // pc_write low: everything holds whatever pc_src/call do
        step(0, 1, 2'd2, 1, 16'h0224, 16'h0000, 16'h0600);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 16'($urandom));
            chk("hold.pc", pc_result, 16'h0600);
            chk("hold.empty", 16'(ras_empty), 16'h0);
            chk_model("hold");
        end

        // nested calls past the stack depth, then unwind past empty
        step(1, 0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            pc_before = pc_result;
            pushed[i] = pc_before + 16'h2;
            step(0, 1, 2'd2, 1, pushed[i], 16'h0, 16'h1000 + 16'(i * 16));
            chk("nest.pc", pc_result, 16'h1000 + 16'(i * 16));
            chk("nest.full", 16'(ras_full), 16'(i >= DEPTH - 1));
            chk("nest.err", 16'(ras_err), 16'(i == DEPTH));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(0, 1, 2'd3, 0, pc_result + 16'h2, 16'h0, 16'h0);
            chk("unwind.pc", pc_result, pushed[i]);
            chk("unwind.empty", 16'(ras_empty), 16'(i == 0));
        end
        step(0, 1, 2'd3, 0, 16'h0010, 16'h0, 16'h0);
        chk("underflow.pc", pc_result, 16'h0010);
        chk("underflow.empty", 16'(ras_empty), 16'h1);
        chk_model("underflow");

        // randomized traffic against the model
        step(1, 0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] add;
            add = ($urandom_range(0, 7) == 0) ? 16'($urandom) : mpc + 16'h2;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 add, 16'($urandom), 16'($urandom));
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter register and next-PC selector for the multicycle RISC datapath. It holds the 16-bit PC and drives it to the PC adder. It takes the adder's PC+2 result back and chooses the next PC from four sources: sequential, branch, jump, or return. A small return-address stack (RAS) provides call/return support. The multicycle control FSM advances the PC only in the cycles where it asserts `pc_write`.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `RAS_DEPTH`, 8, number of RAS entries (power of two, 2..16)

- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  synchronous, active-high reset
- `pc_write`  in  1  PC update enable (one cycle per instruction, driven by the control FSM)
- `pc_src`  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 return
- `call`  in  1  qualifies a jump as a call; sampled only when `pc_write` is high and `pc_src` is 10
- `pc_add_result`  in  16  PC+2 from the PC adder
- `branch_target`  in  16  branch target address
- `jump_target`  in  16  jump/call target address
- `pc_result`  out  16  current PC, fed to the PC adder and the instruction-memory address mux
- `ras_empty`  out  1  RAS holds no entries
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries
- `ras_err`  out  1  sticky flag: RAS overflow or underflow occurred
- `misalign_err`  out  1  sticky flag: odd target address seen (see Configuration)

## Operation
- Reset: `pc_result`=`RESET_PC`, RAS count=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0, `misalign_err`=0. RAS storage contents are don't-care.
- `pc_write`=0: PC, RAS and all flags hold. `pc_src` and `call` are ignored.
- `pc_write`=1, next PC is selected by `pc_src`:
  - 00: `pc_add_result`.
  - 01: `branch_target`.
  - 10: `jump_target`. If `call`=1, push `pc_add_result` onto the RAS.
  - 11: pop the RAS. Next PC = the popped (top) entry.
- `call`=1 with any `pc_src` other than 10 is ignored and causes no push.
- Overflow (push while `ras_full`=1):
  - the jump is still taken;
  - the push is discarded and the stack is unchanged;
  - `ras_err` is set.
- Underflow (pop while `ras_empty`=1):
  - next PC = `pc_add_result` (fall through);
  - count stays 0;
  - `ras_err` is set.
- The RAS is a LIFO with count width clog2(`RAS_DEPTH`)+1. `ras_empty` = (count==0) and `ras_full` = (count==`RAS_DEPTH`), both derived combinationally from the registered count.
- PC arithmetic is done entirely by the external adder. This block adds nothing, and 16'hFFFE+2 wrapping to 16'h0000 passes through unchanged.
- `ras_err` and `misalign_err` clear only on `reset`.

## Timing
- Every state change occurs on the rising edge of `clk` while `pc_write`=1. `pc_result` shows the new PC one cycle after `pc_write` is sampled.
- `pc_result` is a direct register output with no combinational path from any input.
- The RAS top entry is read combinationally from the registered stack. A push and a pop can never coincide, because `pc_src` encodes one action per update.
- Back-to-back `pc_write` cycles are legal, e.g. call then immediate return: the returned PC equals the pushed `pc_add_result`.
- `reset` takes priority over `pc_write` in the same cycle. Reset in mid-sequence discards the RAS contents.
- The flag and count updates from an overflow or underflow are visible on the same edge as the PC update.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - if the selected next PC has bit0=1 for `pc_src` 01, 10 or 11, the PC is not updated;
  - no RAS push or pop occurs in that cycle;
  - `misalign_err` is set.
- `PC_ALIGN_CHECK_EN` undefined:
  - bit0 of the selected next PC is forced to 0 and the update proceeds normally;
  - `misalign_err` is tied to 0.

## Test plan
- Reset with `RESET_PC`=16'h0100, then 3 sequential `pc_write` with adder = PC+2 -> `pc_result` 0100, 0102, 0104, 0106; `ras_empty`=1.
- `pc_write` held low for 5 cycles with a random `pc_src` -> `pc_result` unchanged and no flag changes.
- Call from PC 0x0200 to 0x0400 (`pc_add_result`=0x0202), then return -> PC goes 0x0400, then 0x0202; `ras_empty` is 1 again and `ras_err`=0.
- 9 nested calls with `RAS_DEPTH`=8 -> `ras_full` after the 8th; the 9th call jumps but sets `ras_err`. Then 8 returns give the pushed addresses in reverse order, and a 9th return falls through to `pc_add_result`.
- Return on an empty RAS with `pc_add_result`=0x0010 -> PC=0x0010, `ras_err`=1, `ras_empty` stays 1.
- Jump to 0x0301: with `PC_ALIGN_CHECK_EN`, PC holds and `misalign_err`=1; without it, PC=0x0300 and `misalign_err`=0. `reset` asserted with `pc_write` in the same cycle -> PC=`RESET_PC` and all flags are 0.
